// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment time-display reader: segment patterns,
// datapath widths and the conversion FSM states.
package seg_pkg;
  localparam int CNT_W = 20;
  localparam int SEG_W = 7;

  // Active-low patterns, bit 6 = segment g down to bit 0 = segment a
  localparam logic [SEG_W-1:0] SEG_D0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_D1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_D2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_D3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_D4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_D5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_D6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_D7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_D8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_D9 = 7'b0010000;

  typedef enum logic [1:0] {IDLE, DECODE, MULT, FINISH} state_t;
endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational seven-segment pattern to BCD digit decoder; any pattern that is
// not one of the ten digit shapes reports valid_o=0.
module seg7_digit_dec
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [3:0]       digit_o,
  output logic             valid_o
);
  always_comb begin
    digit_o = 4'd0;
    valid_o = 1'b1;
    case (seg_i)
      SEG_D0: digit_o = 4'd0;
      SEG_D1: digit_o = 4'd1;
      SEG_D2: digit_o = 4'd2;
      SEG_D3: digit_o = 4'd3;
      SEG_D4: digit_o = 4'd4;
      SEG_D5: digit_o = 4'd5;
      SEG_D6: digit_o = 4'd6;
      SEG_D7: digit_o = 4'd7;
      SEG_D8: digit_o = 4'd8;
      SEG_D9: digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg_to_count.sv
// Reads a mm:ss.ff seven-segment display back into a tick count,
// count = (min*60+sec)*hex_num + frac. Define SEG_TO_COUNT_RANGE_CHK_EN to also
// reject sec>=60, frac>=hex_num and hex_num==0.
module seg_to_count
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] hex_num,
  input  logic             start,
  input  logic [SEG_W-1:0] HEX0,
  input  logic [SEG_W-1:0] HEX1,
  input  logic [SEG_W-1:0] HEX2,
  input  logic [SEG_W-1:0] HEX3,
  input  logic [SEG_W-1:0] HEX4,
  input  logic [SEG_W-1:0] HEX5,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             err
);
  state_t                  state_q, state_d;
  logic [5:0][SEG_W-1:0]   hex_q, hex_d;
  logic [SEG_W-1:0]        hn_q, hn_d;
  logic [2:0]              cnt_q, cnt_d;   // digit index in DECODE, bit index in MULT
  logic [SEG_W-1:0]        min_q, min_d, sec_q, sec_d, frac_q, frac_d;
  logic                    bad_q, bad_d;
  logic [CNT_W-1:0]        prod_q, prod_d, count_q, count_d;
  logic                    err_q, err_d, done_q, done_d;

  logic [SEG_W-1:0]        cur_seg, acc_cur, acc_nxt;
  logic [3:0]              cur_dig;
  logic                    cur_vld, range_bad, fail;
  logic [CNT_W-1:0]        base;

  assign cur_seg = hex_q[3'd5 - cnt_q];

  seg7_digit_dec u_dec (
    .seg_i   (cur_seg),
    .digit_o (cur_dig),
    .valid_o (cur_vld)
  );

  assign acc_cur = (cnt_q < 3'd2) ? min_q : (cnt_q < 3'd4) ? sec_q : frac_q;
  assign acc_nxt = acc_cur * 7'd10 + {3'b000, cur_dig};
  assign base    = {{(CNT_W-SEG_W){1'b0}}, min_q} * 20'd60
                 + {{(CNT_W-SEG_W){1'b0}}, sec_q};

`ifdef SEG_TO_COUNT_RANGE_CHK_EN
  assign range_bad = (sec_q >= 7'd60) || (frac_q >= hn_q) || (hn_q == '0);
`else
  assign range_bad = 1'b0;
`endif
  assign fail = bad_q | range_bad;

  always_comb begin
    state_d = state_q;
    hex_d   = hex_q;
    hn_d    = hn_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    sec_d   = sec_q;
    frac_d  = frac_q;
    bad_d   = bad_q;
    prod_d  = prod_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        hex_d   = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
        hn_d    = hex_num;
        cnt_d   = '0;
        min_d   = '0;
        sec_d   = '0;
        frac_d  = '0;
        bad_d   = 1'b0;
        prod_d  = '0;
        state_d = DECODE;
      end
      DECODE: begin
        if (cnt_q < 3'd2)      min_d  = acc_nxt;
        else if (cnt_q < 3'd4) sec_d  = acc_nxt;
        else                   frac_d = acc_nxt;
        bad_d = bad_q | ~cur_vld;
        if (cnt_q == 3'd5) begin
          cnt_d   = '0;
          state_d = MULT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      MULT: begin
        // One multiplier bit per cycle, LSB first
        if (hn_q[cnt_q]) prod_d = prod_q + (base << cnt_q);
        if (cnt_q == 3'd6) begin
          cnt_d   = '0;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      FINISH: begin
        count_d = fail ? '0 : prod_q + {{(CNT_W-SEG_W){1'b0}}, frac_q};
        err_d   = fail;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hex_q   <= '0;
      hn_q    <= '0;
      cnt_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      frac_q  <= '0;
      bad_q   <= 1'b0;
      prod_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hex_q   <= hex_d;
      hn_q    <= hn_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      frac_q  <= frac_d;
      bad_q   <= bad_d;
      prod_q  <= prod_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign count = count_q;
  assign err   = err_q;
endmodule

// File: tb/tb_seg_to_count.sv
// Directed bench for seg_to_count: expected {count, err} is pushed when a
// conversion is launched and popped when done pulses.
module tb_seg_to_count;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [6:0]  hex_num, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        busy, done, err;
  logic [19:0] count;

  always #5 clk = ~clk;

  seg_to_count dut (
    .clk(clk), .rst(rst), .hex_num(hex_num), .start(start),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  typedef struct packed { logic [19:0] cnt; logic err; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input int d5, d4, d3, d2, d1, d0, input int hn);
    exp_t e;
    bit bad;
    int mn, sc, fr;
    bad = (d5 < 0) || (d4 < 0) || (d3 < 0) || (d2 < 0) || (d1 < 0) || (d0 < 0);
    mn = d5 * 10 + d4;
    sc = d3 * 10 + d2;
    fr = d1 * 10 + d0;
`ifdef SEG_TO_COUNT_RANGE_CHK_EN
    if (sc >= 60 || fr >= hn || hn == 0) bad = 1'b1;
`endif
    e.err = bad;
    e.cnt = bad ? 20'd0 : 20'((mn * 60 + sc) * hn + fr);
    return e;
  endfunction

  task automatic launch(input int d5, d4, d3, d2, d1, d0, input int hn,
                        input bit push, input bit hold);
    @(negedge clk);
    HEX5 = pat(d5); HEX4 = pat(d4); HEX3 = pat(d3);
    HEX2 = pat(d2); HEX1 = pat(d1); HEX0 = pat(d0);
    hex_num = 7'(hn);
    start = 1'b1;
    if (push) sb.push_back(model(d5, d4, d3, d2, d1, d0, hn));
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input bit scramble, input bit poke, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (poke) start = (i == 3);
      if (scramble) begin
        HEX0 = 7'($urandom); HEX1 = 7'($urandom); HEX2 = 7'($urandom);
        HEX3 = 7'($urandom); HEX4 = 7'($urandom); HEX5 = 7'($urandom);
        hex_num = 7'($urandom);
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    if (poke) start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat);
    exp_t e;
    chk({tag, "_lat"}, lat, 14);
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_count"}, {12'd0, count}, {12'd0, e.cnt});
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  task automatic conv(input string tag, input int d5, d4, d3, d2, d1, d0, input int hn,
                      input bit scramble, input bit poke);
    int lat;
    launch(d5, d4, d3, d2, d1, d0, hn, 1'b1, 1'b0);
    wait_done(scramble, poke, lat);
    check_result(tag, lat);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic no_done_window(input string tag, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk(tag, n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; hex_num = '0;
    HEX0 = '0; HEX1 = '0; HEX2 = '0; HEX3 = '0; HEX4 = '0; HEX5 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {12'd0, count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    conv("basic", 0, 1, 2, 3, 4, 5, 100, 1'b0, 1'b0);
    chk("basic_abs", {12'd0, count}, 32'd8345);
    conv("max", 9, 9, 5, 9, 9, 9, 100, 1'b0, 1'b0);
    conv("zero", 0, 0, 0, 0, 0, 0, 100, 1'b0, 1'b0);
    conv("blank", 0, 1, 2, -1, 4, 5, 100, 1'b0, 1'b0);
    conv("sec60", 0, 0, 6, 0, 0, 7, 100, 1'b0, 1'b0);
    conv("hn0", 0, 1, 0, 0, 2, 5, 0, 1'b0, 1'b0);
    conv("hn127", 9, 9, 5, 9, 1, 2, 127, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      conv("rand", $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 5),
           $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
           $urandom_range(1, 127), 1'b0, 1'b0);

    // Inputs churn every cycle after the start edge
    conv("scramble", 3, 7, 4, 2, 1, 8, 50, 1'b1, 1'b0);

    // Extra start during DECODE must not launch a second conversion
    conv("poke", 1, 2, 3, 4, 5, 6, 90, 1'b0, 1'b1);
    no_done_window("poke_single", 20);

    // Abort in the third MULT cycle
    conv("pre_abort", 0, 1, 2, 3, 4, 5, 100, 1'b0, 1'b0);
    launch(5, 5, 5, 5, 5, 5, 99, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count", {12'd0, count}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    no_done_window("abort_nodone", 20);

    // Reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; start = 1'b0;
    no_done_window("rst_prio_nodone", 16);

    // Start held high restarts on the first IDLE cycle after FINISH
    launch(0, 2, 1, 0, 3, 3, 64, 1'b1, 1'b1);
    sb.push_back(model(0, 2, 1, 0, 3, 3, 64));
    wait_done(1'b0, 1'b0, lat);
    check_result("hold1", lat);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_rebusy", {31'd0, busy}, 32'd1);
    wait_done(1'b0, 1'b0, lat);
    check_result("hold2", lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
